// File: rtl/regfile_bank_pkg.sv
// Shared definitions for the regfile_bank register file: FSM encodings,
// default geometry and the address range check used by both read ports.
package regfile_bank_pkg;

    localparam int DEFAULT_BITWIDTH = 32;
    localparam int DEFAULT_DEPTH    = 16;
    localparam int NUM_RD_PORTS     = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // DEPTH need not be a power of two, so an index can be representable yet absent.
    function automatic logic addr_in_range(input int addr, input int depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: range check, optional write-to-read forwarding, and the
// registered data/valid outputs with one-cycle latency.
module regfile_rdport
    import regfile_bank_pkg::*;
#(
    parameter int BITWIDTH = DEFAULT_BITWIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [BITWIDTH-1:0] mem_data,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [BITWIDTH-1:0] wr_data,
    output logic [BITWIDTH-1:0] data,
    output logic                valid
);

    logic                in_range;
    logic                fwd;
    logic [BITWIDTH-1:0] data_next;
    logic [BITWIDTH-1:0] data_reg;
    logic                valid_reg;

    assign in_range = addr_in_range(int'(addr), DEPTH);
    assign fwd      = (BYPASS != 0) && wr_en && (wr_addr == addr);

    always_comb begin
        data_next = '0;
        if (in_range) begin
            data_next = fwd ? wr_data : mem_data;
        end
    end

    // Data only moves on an accepted read, so it holds between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= en;
            if (en) begin
                data_reg <= data_next;
            end
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/regfile_bank.sv
// Register file with one write port and two independent registered read
// ports, plus a zero-sweep FSM that clears every entry after reset or clr.
module regfile_bank
    import regfile_bank_pkg::*;
#(
    parameter int BITWIDTH = DEFAULT_BITWIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [BITWIDTH-1:0] wr_data,
    input  logic                rd_en0,
    input  logic [ADDR_W-1:0]   rd_addr0,
    input  logic                rd_en1,
    input  logic [ADDR_W-1:0]   rd_addr1,
    output logic [BITWIDTH-1:0] rd_data0,
    output logic                rd_valid0,
    output logic [BITWIDTH-1:0] rd_data1,
    output logic                rd_valid1
);

    state_t              state_reg;
    logic [ADDR_W-1:0]   ptr_reg;
    logic [BITWIDTH-1:0] mem [DEPTH];

    logic                idle;
    logic                wr_fire;
    logic [NUM_RD_PORTS-1:0] rd_en_vec;
    logic [ADDR_W-1:0]   rd_addr_arr  [NUM_RD_PORTS];
    logic [BITWIDTH-1:0] rd_data_arr  [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] rd_valid_vec;

    assign busy    = (state_reg == ST_SWEEP);
    assign idle    = (state_reg == ST_IDLE);
    assign wr_fire = idle && wr_en && addr_in_range(int'(wr_addr), DEPTH);

    // A clr seen mid-sweep is dropped; only reset restarts a running sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_SWEEP;
            ptr_reg   <= '0;
        end else begin
            case (state_reg)
                ST_SWEEP: begin
                    if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg <= ST_IDLE;
                        ptr_reg   <= '0;
                    end else begin
                        ptr_reg <= ptr_reg + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state_reg <= ST_SWEEP;
                        ptr_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_SWEEP;
                    ptr_reg   <= '0;
                end
            endcase
        end
    end

    // Storage carries no reset; the sweep is what clears it.
    always_ff @(posedge clk) begin
        if (state_reg == ST_SWEEP) begin
            mem[ptr_reg] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_en_vec      = {rd_en1, rd_en0};
    assign rd_addr_arr[0] = rd_addr0;
    assign rd_addr_arr[1] = rd_addr1;

    generate
        for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rdport
            logic [ADDR_W-1:0]   rd_idx;
            logic [BITWIDTH-1:0] mem_rdata;

            // Out-of-range addresses are steered to entry 0; the port zeroes the result.
            assign rd_idx    = addr_in_range(int'(rd_addr_arr[gi]), DEPTH) ? rd_addr_arr[gi] : '0;
            assign mem_rdata = mem[rd_idx];

            regfile_rdport #(
                .BITWIDTH (BITWIDTH),
                .DEPTH    (DEPTH),
                .BYPASS   (BYPASS),
                .ADDR_W   (ADDR_W)
            ) u_rdport (
                .clk      (clk),
                .rst      (rst),
                .en       (idle && rd_en_vec[gi]),
                .addr     (rd_addr_arr[gi]),
                .mem_data (mem_rdata),
                .wr_en    (wr_fire),
                .wr_addr  (wr_addr),
                .wr_data  (wr_data),
                .data     (rd_data_arr[gi]),
                .valid    (rd_valid_vec[gi])
            );
        end
    endgenerate

    assign rd_data0  = rd_data_arr[0];
    assign rd_data1  = rd_data_arr[1];
    assign rd_valid0 = rd_valid_vec[0];
    assign rd_valid1 = rd_valid_vec[1];

endmodule
